grey_seq_monitor: RTL
=====================

// Module: grey_seq_monitor
// PURPOSE
//  Sits directly downstream of the Gray-code counter FSM. Consumes its Gray-coded
//  count and its registered wrap pulse; converts each sample to binary, checks the
//  sample-to-sample step and the wrap-pulse alignment, and counts completed wraps.
//  A lock/track/fault state machine reports whether the upstream sequence is trusted.
// PARAMETERS
//  SIZE       3   width of Gray input and binary output
//  EPOCH_W    8   width of wrap (epoch) counter
//  LOCK_CNT   2   consecutive legal steps required to enter TRACK (1..2^SIZE)
//  ALLOW_HOLD 0   1: repeated sample (step 0) is legal; 0: it is a step error
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        synchronous, active-high
//  sample_en  in   1        grey_in/wrap_in valid this cycle (tie 1 when counter runs every clk)
//  grey_in    in   SIZE     Gray-coded count from upstream
//  wrap_in    in   1        upstream wrap pulse
//  clear_err  in   1        leave FAULT (acts only in FAULT)
//  bin_out    out  SIZE     binary of last accepted grey_in
//  epoch_out  out  EPOCH_W  number of legal wraps seen in TRACK, wraps modulo 2^EPOCH_W
//  valid      out  1        bin_out holds at least one sample
//  locked     out  1        state == TRACK
//  err_step   out  1        one-cycle pulse: illegal step detected
//  err_wrap   out  1        one-cycle pulse: wrap_in / rollover mismatch
//  fault      out  1        state == FAULT
// BEHAVIOUR
//  - Reset: state IDLE; bin_out=0, epoch_out=0, valid=0, locked=0, err_step=0,
//    err_wrap=0, fault=0, lock count=0. Reset dominates every other input.
//  - All outputs registered. Latency 1: bin_out(t+1) = gray2bin(grey_in(t)) when sample_en(t);
//    gray2bin: b[SIZE-1]=g[SIZE-1], b[i]=b[i+1]^g[i]. sample_en=0: everything holds; pulses drop to 0.
//  - Step classification vs previous accepted sample (prev = bin_out):
//    d = (bin_now - prev) mod 2^SIZE. d==1 legal; d==0 legal iff ALLOW_HOLD; else step error.
//    rollover = (prev == 2^SIZE-1) && (bin_now == 0).
//    Wrap mismatch: wrap_in != rollover (wrap_in expected in the same sample as the 0 code).
//  - States (transitions on sampled cycles only):
//    IDLE : first sample captured, valid<=1, lock count<=0, go LOCK. No checks.
//    LOCK : legal step and no wrap mismatch -> count+1; count reaching LOCK_CNT -> TRACK.
//           step error or wrap mismatch -> count<=0, stay LOCK; no error pulses, no epoch count.
//    TRACK: step error -> err_step pulse; wrap mismatch -> err_wrap pulse; either -> FAULT.
//           Legal rollover with wrap_in=1 -> epoch_out+1 (wraps to 0 past 2^EPOCH_W-1).
//           Both errors in one sample: both pulses high same cycle, single FAULT entry.
//    FAULT: bin_out keeps tracking; no checks, no epoch count. clear_err=1 -> IDLE next cycle
//           (valid stays 1, epoch_out retained). clear_err ignored in all other states.
//  - A hold sample (d==0, ALLOW_HOLD=1) never counts as rollover and does not advance lock count.
//  - Reset mid-TRACK/FAULT: all outputs including epoch_out return to reset values next cycle.
// TESTING  (SIZE=3, EPOCH_W=8, LOCK_CNT=2, ALLOW_HOLD=0, sample_en=1 unless stated)
//  1 Reset, feed Gray 000,001,011,010 -> bin_out 0,1,2,3 one cycle later; valid rises after
//    first sample; locked=1 after 3rd sample (2 legal steps).
//  2 Drive upstream counter for 3 full cycles, wrap_in high with each 000 after 100 ->
//    epoch_out 0->1->2->3 (increments on the 000 sample), no error pulses.
//  3 In TRACK feed 010 then 111 (bin 3->5) -> err_step pulses 1 cycle, fault=1, locked=0;
//    bin_out=5; epoch_out frozen.
//  4 In TRACK feed 100 then 000 with wrap_in=0 -> err_wrap pulse, FAULT; separately wrap_in=1
//    on 011 -> err_wrap pulse, FAULT; both errors same sample -> both pulses, one FAULT.
//  5 In FAULT assert clear_err 1 cycle -> IDLE, then LOCK, TRACK after 2 legal steps;
//    clear_err in TRACK -> no effect.
//  6 sample_en=0 for 5 cycles mid-TRACK -> outputs hold; reset asserted with clear_err and
//    bad step -> all outputs 0, state IDLE; set epoch to 255 and wrap -> epoch_out=0.

Source files
------------

// File: rtl/grey_seq_monitor_if.sv
// Bundle between the Gray-code counter, its monitor and whoever consumes the monitor status.
// master drives the sampled count and control; slave is the monitor itself.
interface grey_seq_monitor_if #(
    parameter int unsigned SIZE    = 3,
    parameter int unsigned EPOCH_W = 8
);
    logic               sample_en;
    logic [SIZE-1:0]    grey_in;
    logic               wrap_in;
    logic               clear_err;
    logic [SIZE-1:0]    bin_out;
    logic [EPOCH_W-1:0] epoch_out;
    logic               valid;
    logic               locked;
    logic               err_step;
    logic               err_wrap;
    logic               fault;

    modport master (
        output sample_en, grey_in, wrap_in, clear_err,
        input  bin_out, epoch_out, valid, locked, err_step, err_wrap, fault
    );

    modport slave (
        input  sample_en, grey_in, wrap_in, clear_err,
        output bin_out, epoch_out, valid, locked, err_step, err_wrap, fault
    );
endinterface

// File: rtl/grey_seq_monitor.sv
// Gray-code sequence monitor: converts samples to binary, checks step size and wrap alignment,
// counts wraps while trusted, and tracks trust with an IDLE/LOCK/TRACK/FAULT state machine.
module grey_seq_monitor #(
    parameter int unsigned SIZE       = 3,
    parameter int unsigned EPOCH_W    = 8,
    parameter int unsigned LOCK_CNT   = 2,
    parameter bit          ALLOW_HOLD = 1'b0
) (
    input logic               clk,
    input logic               reset,
    grey_seq_monitor_if.slave bus
);
    localparam int unsigned LockW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {StIdle, StLock, StTrack, StFault} state_e;

    state_e             state_q;
    logic [SIZE-1:0]    bin_q;
    logic [EPOCH_W-1:0] epoch_q;
    logic               valid_q;
    logic               err_step_q;
    logic               err_wrap_q;
    logic [LockW-1:0]   lock_cnt_q;

    logic [SIZE-1:0]  bin_now;
    logic [SIZE-1:0]  step;
    logic             step_legal;
    logic             rollover;
    logic             wrap_bad;
    logic [LockW-1:0] lock_next;

    always_comb begin
        bin_now = '0;
        bin_now[SIZE-1] = bus.grey_in[SIZE-1];
        for (int i = int'(SIZE) - 2; i >= 0; i--) begin
            bin_now[i] = bin_now[i+1] ^ bus.grey_in[i];
        end
        // Step is taken modulo 2^SIZE so the 2^SIZE-1 -> 0 rollover reads as +1.
        step       = bin_now - bin_q;
        step_legal = (step == SIZE'(1)) || (ALLOW_HOLD && (step == '0));
        rollover   = (bin_q == '1) && (bin_now == '0);
        wrap_bad   = bus.wrap_in != rollover;
        lock_next  = lock_cnt_q + LockW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            bin_q      <= '0;
            epoch_q    <= '0;
            valid_q    <= 1'b0;
            err_step_q <= 1'b0;
            err_wrap_q <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            err_step_q <= 1'b0;
            err_wrap_q <= 1'b0;
            if (bus.sample_en) begin
                bin_q <= bin_now;
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.sample_en) begin
                        valid_q    <= 1'b1;
                        lock_cnt_q <= '0;
                        state_q    <= StLock;
                    end
                end
                StLock: begin
                    if (bus.sample_en) begin
                        if (step_legal && !wrap_bad) begin
                            // A legal hold neither advances nor breaks the lock run.
                            if (step != '0) begin
                                lock_cnt_q <= lock_next;
                                if (lock_next == LockW'(LOCK_CNT)) begin
                                    state_q <= StTrack;
                                end
                            end
                        end else begin
                            lock_cnt_q <= '0;
                        end
                    end
                end
                StTrack: begin
                    if (bus.sample_en) begin
                        err_step_q <= !step_legal;
                        err_wrap_q <= wrap_bad;
                        if (!step_legal || wrap_bad) begin
                            state_q <= StFault;
                        end else if (rollover) begin
                            epoch_q <= epoch_q + EPOCH_W'(1);
                        end
                    end
                end
                StFault: begin
                    if (bus.clear_err) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.bin_out   = bin_q;
    assign bus.epoch_out = epoch_q;
    assign bus.valid     = valid_q;
    assign bus.locked    = (state_q == StTrack);
    assign bus.err_step  = err_step_q;
    assign bus.err_wrap  = err_wrap_q;
    assign bus.fault     = (state_q == StFault);
endmodule
